// File: rtl/digit_render_pkg.sv
// Shared constants and types for the digit renderer.
package digit_render_pkg;

    localparam int unsigned GLYPH_W    = 32;
    localparam int unsigned GLYPH_H    = 32;
    localparam logic [7:0]  FG_DEFAULT = 8'hFF;
    localparam logic [7:0]  BG_DEFAULT = 8'h00;
    localparam int unsigned ACTIVE_W   = 640;
    localparam int unsigned ACTIVE_H   = 480;

    typedef logic [3:0] bcd_t;

    // Magnification is restricted to powers of two so coordinates scale by shifting.
    function automatic int unsigned scale_shift(int unsigned scale);
        return (scale >= 4) ? 2 : ((scale >= 2) ? 1 : 0);
    endfunction

endpackage

// File: rtl/digit_font_rom.sv
// Registered glyph ROM: seven-segment style 32x32 digits, one 32-bit line per lookup.
// Bit 31 is the leftmost column; codes above 9 return an empty line.
module digit_font_rom
    import digit_render_pkg::*;
(
    input  logic               clk_dr,
    input  logic               rst_dr,
    input  logic [3:0]         digit_i,
    input  logic [4:0]         row_i,
    output logic [GLYPH_W-1:0] line_o
);

    // Bars occupy columns 6..25 (horizontal), 6..9 (left) and 22..25 (right).
    localparam logic [31:0] BarH = 32'h03FF_FFC0;
    localparam logic [31:0] BarL = 32'h03C0_0000;
    localparam logic [31:0] BarR = 32'h0000_03C0;

    bcd_t        digit;
    logic [6:0]  seg;  // {a, b, c, d, e, f, g}
    logic        top, mid, bot, upper, lower;
    logic [31:0] line_d, line_q;

    assign digit = digit_i;

    always_comb begin
        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        top   = (row_i >= 5'd2)  && (row_i <= 5'd5);
        mid   = (row_i >= 5'd14) && (row_i <= 5'd17);
        bot   = (row_i >= 5'd26) && (row_i <= 5'd29);
        upper = (row_i >= 5'd2)  && (row_i <= 5'd17);
        lower = (row_i >= 5'd14) && (row_i <= 5'd29);
        line_d = '0;
        if (seg[6] && top)   line_d = line_d | BarH;
        if (seg[5] && upper) line_d = line_d | BarR;
        if (seg[4] && lower) line_d = line_d | BarR;
        if (seg[3] && bot)   line_d = line_d | BarH;
        if (seg[2] && lower) line_d = line_d | BarL;
        if (seg[1] && upper) line_d = line_d | BarL;
        if (seg[0] && mid)   line_d = line_d | BarH;
    end

    always_ff @(posedge clk_dr) begin
        if (rst_dr) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/digit_render.sv
// Three-stage pixel renderer for a row of BCD digits with frame-synchronous updates.
// Optional per-cell blinking is enabled by defining DIGIT_RENDER_BLINK_EN.
module digit_render
    import digit_render_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCALE      = 2,
    parameter int unsigned X0         = 128,
    parameter int unsigned Y0         = 96,
    parameter int unsigned GAP        = 8,
    parameter logic [7:0]  FG_COLOR   = FG_DEFAULT,
    parameter logic [7:0]  BG_COLOR   = BG_DEFAULT
) (
    input  logic                    clk_dr,
    input  logic                    rst_dr,
    input  logic [9:0]              h_index,
    input  logic [9:0]              v_index,
    input  logic                    visible_in,
    input  logic                    frame_sync_in,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask_in,
    output logic [7:0]              color_out
);

    localparam int unsigned CELL_W = GLYPH_W * SCALE;
    localparam int unsigned CELL_H = GLYPH_H * SCALE;
    localparam int unsigned PITCH  = CELL_W + GAP;
    localparam int unsigned SHIFT  = scale_shift(SCALE);

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   blink_cells;
    logic                    blink_on;

    logic        vis1_q, vis1_d, hit1_q, hit1_d;
    logic [2:0]  idx1_q, idx1_d;
    logic [4:0]  row1_q, row1_d, col1_q, col1_d;
    logic        vis2_q, vis2_d, hit2_q, hit2_d, blank2_q, blank2_d;
    logic [4:0]  col2_q, col2_d;
    logic [7:0]  color_q, color_d;
    logic [31:0] dx, dy, line;
    logic        in_area;
    bcd_t        dig_sel;

    assign shadow_d = frame_sync_in ? digits_in : shadow_q;

`ifdef DIGIT_RENDER_BLINK_EN
    logic [NUM_DIGITS-1:0] blink_q, blink_d;
    logic [5:0]            frame_cnt_q, frame_cnt_d;

    always_comb begin
        blink_d     = frame_sync_in ? blink_mask_in : blink_q;
        frame_cnt_d = frame_sync_in ? frame_cnt_q + 6'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk_dr) begin
        if (rst_dr) begin
            blink_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            blink_q     <= blink_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign blink_cells = blink_q;
    assign blink_on    = frame_cnt_q[5];
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask_in;
    assign blink_cells       = '0;
    assign blink_on          = 1'b0;
`endif

    // Stage 1: locate the cell; out-of-range offsets wrap to huge values and miss.
    always_comb begin
        hit1_d  = 1'b0;
        idx1_d  = '0;
        col1_d  = '0;
        dx      = '0;
        vis1_d  = visible_in;
        dy      = 32'(v_index) - Y0;
        row1_d  = 5'(dy >> SHIFT);
        in_area = (32'(h_index) < ACTIVE_W) && (32'(v_index) < ACTIVE_H) && (dy < CELL_H);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dx = 32'(h_index) - (X0 + 32'(i) * PITCH);
            if (in_area && (dx < CELL_W)) begin
                hit1_d = 1'b1;
                idx1_d = 3'(i);
                col1_d = 5'(dx >> SHIFT);
            end
        end
    end

    // Stage 2 inputs: shadow digit and blink state for the stage-1 cell.
    always_comb begin
        dig_sel  = 4'hF;
        blank2_d = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx1_q == 3'(i)) begin
                dig_sel  = shadow_q[4*(NUM_DIGITS-1-i) +: 4];
                blank2_d = blink_cells[i] & blink_on;
            end
        end
        vis2_d = vis1_q;
        hit2_d = hit1_q;
        col2_d = col1_q;
    end

    digit_font_rom u_font_rom (
        .clk_dr  (clk_dr),
        .rst_dr  (rst_dr),
        .digit_i (dig_sel),
        .row_i   (row1_q),
        .line_o  (line)
    );

    always_comb begin
        color_d = 8'h00;
        if (vis2_q) begin
            color_d = (hit2_q && !blank2_q && line[5'd31 - col2_q]) ? FG_COLOR : BG_COLOR;
        end
    end

    always_ff @(posedge clk_dr) begin
        if (rst_dr) begin
            shadow_q <= '0;
            vis1_q   <= 1'b0;
            hit1_q   <= 1'b0;
            idx1_q   <= '0;
            row1_q   <= '0;
            col1_q   <= '0;
            vis2_q   <= 1'b0;
            hit2_q   <= 1'b0;
            blank2_q <= 1'b0;
            col2_q   <= '0;
            color_q  <= 8'h00;
        end else begin
            shadow_q <= shadow_d;
            vis1_q   <= vis1_d;
            hit1_q   <= hit1_d;
            idx1_q   <= idx1_d;
            row1_q   <= row1_d;
            col1_q   <= col1_d;
            vis2_q   <= vis2_d;
            hit2_q   <= hit2_d;
            blank2_q <= blank2_d;
            col2_q   <= col2_d;
            color_q  <= color_d;
        end
    end

    assign color_out = color_q;

endmodule

// File: tb/tb_digit_render.sv
// Self-checking bench for digit_render: directed scans plus random pixels against a
// geometric seven-segment reference model.
module tb_digit_render;

    localparam int X0    = 128;
    localparam int Y0    = 96;
    localparam int PITCH = 72;
    localparam int CELL  = 64;
    localparam logic [7:0] FG = 8'hFF;
    localparam logic [7:0] BG = 8'h00;
`ifdef DIGIT_RENDER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h, v;
    logic        vis, fs;
    logic [15:0] digits;
    logic [3:0]  blink;
    logic [7:0]  color_out;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: shadow digits, blink mask, frame count, expected-output delay line.
    logic [15:0] sh_m;
    logic [3:0]  bl_m;
    int          cnt_m;
    logic [7:0]  pipe [3];

    // Segment rectangles in glyph (row, col) space, order a..g.
    int rlo [7] = '{2, 2, 14, 26, 14, 2, 14};
    int rhi [7] = '{5, 17, 29, 29, 29, 17, 17};
    int clo [7] = '{6, 22, 22, 6, 6, 6, 6};
    int chi [7] = '{25, 25, 25, 25, 9, 9, 25};
    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    always #5 clk = ~clk;

    digit_render dut (
        .clk_dr        (clk),
        .rst_dr        (rst),
        .h_index       (h),
        .v_index       (v),
        .visible_in    (vis),
        .frame_sync_in (fs),
        .digits_in     (digits),
        .blink_mask_in (blink),
        .color_out     (color_out)
    );

    function automatic bit lit(int d, int row, int col);
        logic [6:0] s;
        s = seg_tab[d];
        for (int k = 0; k < 7; k++) begin
            if (s[6-k] && row >= rlo[k] && row <= rhi[k] && col >= clo[k] && col <= chi[k])
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] model_px(int x, int y, logic vi);
        if (!vi) return 8'h00;
        for (int i = 0; i < 4; i++) begin
            int left;
            int d;
            left = X0 + i * PITCH;
            if (x >= left && x < left + CELL && y >= Y0 && y < Y0 + CELL) begin
                d = int'((sh_m >> (4 * (3 - i))) & 16'h000F);
                if (BLINK && bl_m[i] && (cnt_m % 64) >= 32) return BG;
                if (d > 9) return BG;
                return lit(d, (y - Y0) / 2, (x - left) / 2) ? FG : BG;
            end
        end
        return BG;
    endfunction

    task automatic tick(input string tag);
        logic [7:0] e;
        @(posedge clk);
        if (rst) begin
            sh_m = '0; bl_m = '0; cnt_m = 0;
            pipe[0] = 8'h00; pipe[1] = 8'h00; pipe[2] = 8'h00;
        end else begin
            if (fs) begin
                sh_m  = digits;
                bl_m  = blink;
                cnt_m = (cnt_m + 1) % 64;
            end
            e = model_px(int'(h), int'(v), vis);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e;
        end
        #1;
        vectors++;
        assert (color_out === pipe[2]) else begin
            miscompares++;
            $error("FAIL %s: color_out=%h expected=%h (h=%0d v=%0d)",
                   tag, color_out, pipe[2], h, v);
        end
    endtask

    task automatic scan_row(input int y, input int xa, input int xb, input string tag);
        v   = 10'(y);
        vis = 1'b1;
        for (int x = xa; x <= xb; x++) begin
            h = 10'(x);
            tick(tag);
        end
    endtask

    task automatic pulse_fs(input logic [15:0] d, input logic [3:0] m);
        digits = d;
        blink  = m;
        vis    = 1'b0;
        fs     = 1'b1;
        tick("fs_pulse");
        fs     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; h = 10'd130; v = 10'd100; vis = 1'b1; fs = 1'b0;
        digits = 16'h1234; blink = 4'b0000;
        // Reset held while scanning; a simultaneous frame sync must be ignored.
        tick("reset_hold");
        fs = 1'b1;
        h = 10'd140; tick("reset_vs_fs");
        fs = 1'b0;
        h = 10'd150; tick("reset_hold");
        rst = 1'b0;
        scan_row(100, 120, 415, "post_reset_0000");

        pulse_fs(16'h1234, 4'b0000);
        scan_row(96, 128, 407, "render_row0");
        scan_row(100, 120, 415, "render_row2");
        scan_row(110, 120, 415, "render_row7");
        scan_row(127, 120, 415, "render_row15");
        scan_row(150, 120, 415, "render_row27");

        // Mid-frame digit change without a frame sync must not show.
        digits = 16'h9999;
        scan_row(110, 120, 415, "no_tearing");
        pulse_fs(16'h9999, 4'b0000);
        scan_row(110, 120, 415, "after_sync_9999");

        pulse_fs(16'h12A4, 4'b0000);
        scan_row(100, 120, 415, "invalid_bcd");
        scan_row(140, 260, 345, "invalid_bcd_cell2");

        // Blanking inside cell 0.
        v = 10'd100; vis = 1'b0;
        for (int x = 128; x < 192; x += 4) begin
            h = 10'(x);
            tick("blanking");
        end

        // Frame sync during visible pixels.
        v = 10'd100; vis = 1'b1;
        digits = 16'h8888;
        for (int x = 180; x < 300; x++) begin
            h  = 10'(x);
            fs = (x == 220);
            tick("fs_mid_line");
        end
        fs = 1'b0;

        // Reset mid-line flushes the pipeline and clears the shadow.
        for (int x = 130; x < 200; x++) begin
            h   = 10'(x);
            rst = (x >= 150 && x < 152);
            tick("reset_mid_line");
        end
        rst = 1'b0;

        // Random pixels, visibility and occasional frame syncs with arbitrary nibbles.
        for (int n = 0; n < 3000; n++) begin
            h   = 10'($urandom_range(100, 430));
            v   = 10'($urandom_range(80, 180));
            vis = ($urandom_range(0, 7) != 0);
            fs  = ($urandom_range(0, 49) == 0);
            if (fs) begin
                digits = 16'($urandom);
                blink  = 4'($urandom);
            end
            tick("random");
        end
        fs = 1'b0;

        // Blink across frame-counter wrap; without the feature the mask is ignored.
        for (int f = 0; f < 70; f++) begin
            pulse_fs(16'h1238, 4'b1000);
            v = 10'd100; vis = 1'b1;
            for (int x = 356; x < 400; x += 8) begin
                h = 10'(x);
                tick("blink_cell3");
            end
            h = 10'd170;
            tick("blink_cell0");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
